// File: rtl/burst_addr_scheduler_pkg.sv
// Shared constants for the two-requester burst address scheduler.
// FSM state encoding and default bus/burst geometry live here.
package burst_addr_scheduler_pkg;

  localparam int DEFAULT_ADDR_W    = 3;
  localparam int DEFAULT_BURST_LEN = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GRANT = 2'd1;
  localparam state_t ST_BURST = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/burst_addr_scheduler_if.sv
// Requester/memory-side bundle of the burst address scheduler.
// The scheduler uses the slave modport; the requester side uses master.
interface burst_addr_scheduler_if
  import burst_addr_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic [1:0]        req_i;
  logic [ADDR_W-1:0] base0_i;
  logic [ADDR_W-1:0] base1_i;
  logic [1:0]        gnt_o;
  logic [ADDR_W-1:0] add_o;
  logic              OE_R;
  logic [1:0]        done_o;
  logic              busy_o;

  modport master (
    output req_i, base0_i, base1_i,
    input  gnt_o, add_o, OE_R, done_o, busy_o
  );

  modport slave (
    input  req_i, base0_i, base1_i,
    output gnt_o, add_o, OE_R, done_o, busy_o
  );

endinterface

// File: rtl/burst_addr_scheduler_arbiter.sv
// Two-way arbiter: combinational winner select. With SCHED_ROUND_ROBIN_EN
// defined a last-winner pointer alternates contention; otherwise requester 0 wins.
module sched_arbiter2
  import burst_addr_scheduler_pkg::*;
(
`ifdef SCHED_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       srst,
  input  logic       grant_en,
`endif
  input  logic [1:0] req,
  output logic [1:0] winner
);

`ifdef SCHED_ROUND_ROBIN_EN
  // Resets to requester 1 so that requester 0 takes the first contended grant.
  logic last_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      last_reg <= 1'b1;
    end else if (grant_en) begin
      last_reg <= winner[1];
    end
  end

  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = onehot2(~last_reg);
    end
  end
`else
  always_comb begin
    winner = req[0] ? 2'b01 : {req[1], 1'b0};
  end
`endif

endmodule

// File: rtl/burst_addr_scheduler.sv
// Burst address scheduler top: IDLE -> GRANT -> BURST (BURST_LEN beats) -> DONE.
// Optional round-robin arbitration via macro SCHED_ROUND_ROBIN_EN.
module burst_addr_scheduler
  import burst_addr_scheduler_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
  input logic                   CLK,
  input logic                   RST,
  burst_addr_scheduler_if.slave bus
);

  localparam int                CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state_reg;
  logic [1:0]        gnt_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] add_reg;
  logic              oe_reg;
  logic [1:0]        done_reg;
  logic              busy_reg;
  logic [CNT_W-1:0]  beat_reg;

  logic [1:0]        winner;
  logic [ADDR_W-1:0] win_base;
  logic              grant_en;

  assign grant_en = (state_reg == ST_IDLE) && (bus.req_i != 2'b00);
  assign win_base = winner[1] ? bus.base1_i : bus.base0_i;

  sched_arbiter2 u_arbiter (
`ifdef SCHED_ROUND_ROBIN_EN
    .clk      (CLK),
    .srst     (RST),
    .grant_en (grant_en),
`endif
    .req      (bus.req_i),
    .winner   (winner)
  );

  // beat_reg counts beats already presented; the burst ends once it reaches BURST_LEN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= 2'b00;
      base_reg  <= '0;
      add_reg   <= '0;
      oe_reg    <= 1'b0;
      done_reg  <= 2'b00;
      busy_reg  <= 1'b0;
      beat_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_en) begin
            state_reg <= ST_GRANT;
            gnt_reg   <= winner;
            base_reg  <= win_base;
            add_reg   <= win_base;
            busy_reg  <= 1'b1;
          end
        end
        ST_GRANT: begin
          state_reg <= ST_BURST;
          add_reg   <= base_reg;
          oe_reg    <= 1'b1;
          beat_reg  <= CNT_ONE;
        end
        ST_BURST: begin
          if (beat_reg == LAST_BEAT) begin
            state_reg <= ST_DONE;
            oe_reg    <= 1'b0;
            done_reg  <= gnt_reg;
            add_reg   <= '0;
          end else begin
            add_reg  <= add_reg + ADDR_ONE;
            beat_reg <= beat_reg + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          gnt_reg   <= 2'b00;
          done_reg  <= 2'b00;
          busy_reg  <= 1'b0;
          beat_reg  <= '0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_o  = gnt_reg;
  assign bus.add_o  = add_reg;
  assign bus.OE_R   = oe_reg;
  assign bus.done_o = done_reg;
  assign bus.busy_o = busy_reg;

endmodule

// File: tb/tb_burst_addr_scheduler.sv
// Drives three scheduler builds (BURST_LEN 4, 1, 8) with shared stimulus and
// compares every output each cycle against a burst-trace reference model.
`timescale 1ns/1ps
module tb_burst_addr_scheduler;

  localparam int AW = 3;

  typedef struct {
    logic [1:0]    gnt;
    logic [AW-1:0] add;
    logic          oe;
    logic [1:0]    done;
    logic          busy;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [AW-1:0] base0 = '0;
  logic [AW-1:0] base1 = '0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d at %0t", tag, got, exp, $time);
  endtask

  // Arbitration rule: single requester wins; contention goes to 0 (fixed) or to the one not granted last.
  function automatic int pick(input logic [1:0] r, input int last);
`ifdef SCHED_ROUND_ROBIN_EN
    if (r == 2'b11) return (last == 0) ? 1 : 0;
`else
    if (r == 2'b11) return 0;
`endif
    return r[0] ? 0 : 1;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int BL = (gi == 0) ? 4 : (gi == 1) ? 1 : 8;

    burst_addr_scheduler_if #(.ADDR_W(AW)) bus ();

    assign bus.req_i   = req;
    assign bus.base0_i = base0;
    assign bus.base1_i = base1;

    burst_addr_scheduler #(.ADDR_W(AW), .BURST_LEN(BL)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
    );

    exp_t          q[$];
    exp_t          e;
    int            last_w = 1;
    int            w;
    int            b;

    always begin
      @(posedge CLK);
      #1;
      if (RST) begin
        q.delete();
        last_w = 1;
        e = '{gnt: 2'b00, add: '0, oe: 1'b0, done: 2'b00, busy: 1'b0};
      end else begin
        if (q.size() == 0) begin
          if (req != 2'b00) begin
            // Whole burst trace: grant cycle, BURST_LEN beats, done cycle, one idle cycle.
            w = pick(req, last_w);
            last_w = w;
            b = (w == 0) ? int'(base0) : int'(base1);
            q.push_back('{gnt: 2'(1 << w), add: AW'(b), oe: 1'b0, done: 2'b00, busy: 1'b1});
            for (int k = 0; k < BL; k++)
              q.push_back('{gnt: 2'(1 << w), add: AW'((b + k) % (1 << AW)), oe: 1'b1, done: 2'b00, busy: 1'b1});
            q.push_back('{gnt: 2'(1 << w), add: '0, oe: 1'b0, done: 2'(1 << w), busy: 1'b1});
            q.push_back('{gnt: 2'b00, add: '0, oe: 1'b0, done: 2'b00, busy: 1'b0});
            e = q.pop_front();
          end else begin
            e = '{gnt: 2'b00, add: '0, oe: 1'b0, done: 2'b00, busy: 1'b0};
          end
        end else begin
          e = q.pop_front();
        end
      end
      check($sformatf("bl%0d.gnt", BL),  bus.gnt_o,  e.gnt);
      check($sformatf("bl%0d.add", BL),  bus.add_o,  e.add);
      check($sformatf("bl%0d.oe", BL),   bus.OE_R,   e.oe);
      check($sformatf("bl%0d.done", BL), bus.done_o, e.done);
      check($sformatf("bl%0d.busy", BL), bus.busy_o, e.busy);
      if (e.done != 2'b00)
        $display("[%0t] bl=%0d burst complete: requester %0d, base %0d", $time, BL, (e.done == 2'b10) ? 1 : 0, b);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    cycles(3);
    RST = 1'b0;

    // requester 0 from base 0
    req = 2'b01; base0 = 3'd0;
    cycles(1); req = 2'b00;
    cycles(12);

    // requester 1 from base 6: wraps 6,7,0,1...
    req = 2'b10; base1 = 3'd6;
    cycles(1); req = 2'b00;
    cycles(12);

    // sustained contention
    req = 2'b11; base0 = 3'd1; base1 = 3'd4;
    cycles(40);
    req = 2'b00;
    cycles(12);

    // one-cycle request pulse, base moved mid-burst
    req = 2'b01; base0 = 3'd0;
    cycles(1); req = 2'b00;
    cycles(2); base0 = 3'd5;
    cycles(12);

    // reset on the second beat, then a clean burst from base 3
    req = 2'b01; base0 = 3'd2;
    cycles(1); req = 2'b00;
    cycles(1); RST = 1'b1;
    cycles(1); RST = 1'b0;
    cycles(2);
    req = 2'b10; base1 = 3'd3;
    cycles(1); req = 2'b00;
    cycles(12);

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      req   = 2'($urandom_range(0, 3));
      base0 = AW'($urandom);
      base1 = AW'($urandom);
      RST   = ($urandom_range(0, 79) == 0);
      cycles(1);
    end
    RST = 1'b0; req = 2'b00;
    cycles(14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
